demux_tdm: RTL and testbench
============================

# demux_tdm

Time-division demultiplexer: the receive end of the 4-channel slot-multiplexed link driven by the structural 4:1 mux. Accepts one sample per valid cycle from the shared line and aligns to a frame-sync marker on slot 0. It collects the samples into per-channel registers and presents a complete, parallel frame with a one-cycle valid pulse. It sits after the mux/serial link and feeds channel-parallel consumers.

## Interface
- `WIDTH`, 1: bits per sample (per channel).
- `N_CH`, 4: channels per frame; power of two, ≥2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `din`  in  WIDTH  sample from the multiplexed line.
- `din_valid`  in  1  `din` carries a sample this cycle.
- `frame_sync`  in  1  qualifies the current valid sample as slot 0; ignored when `din_valid`=0.
- `dout`  out  N_CH*WIDTH  last complete frame; channel i at `[i*WIDTH +: WIDTH]`.
- `dout_valid`  out  1  one-cycle pulse: `dout` just updated.
- `slot`  out  log2(N_CH)  slot index the next valid sample is written to.
- `locked`  out  1  high in LOCKED state.
- `sync_err`  out  1  one-cycle pulse: sync seen at a non-zero slot.

## Operation
- Reset (`rst_n`=0 at an edge): state HUNT, `slot`=0, shadow regs=0, `dout`=0, `dout_valid`=0, `locked`=0, `sync_err`=0. Reset mid-frame discards the partial frame; `dout` clears.
- HUNT: valid samples without `frame_sync` are dropped, `slot` held at 0. A valid sample with `frame_sync`=1 is written to shadow[0], `slot`→1, state→LOCKED.
- LOCKED: each valid sample is written to shadow[`slot`], and `slot` increments modulo N_CH. Cycles with `din_valid`=0 change nothing (gaps allowed inside a frame).
- Frame completion: the valid sample at `slot`=N_CH-1 loads `dout` with shadow[0..N_CH-2] plus that sample, in the same edge. It sets `dout_valid`=1 for the following cycle, and `slot` wraps to 0.
- `frame_sync` with a valid sample at `slot`=0 in LOCKED: normal, no error.
- `frame_sync` with a valid sample at `slot`≠0 (sync check enabled): `sync_err` pulses. The partial frame is discarded, the sample goes to shadow[0], `slot`→1, state stays LOCKED, and `dout` is not updated.
- `dout` holds its value between frames. A completion and a sync error never coincide, because a sync sample occupies slot 0.

## Timing
- Latency: the last sample of a frame is sampled at edge k; `dout` and `dout_valid` are valid after edge k and `dout_valid` drops after edge k+1.
- Back-to-back frames with `din_valid` held high give one `dout_valid` pulse every N_CH cycles.
- `slot`, `locked`, and `sync_err` are registered; there are no combinational input→output paths.

## Configuration
- `DEMUX_TDM_SYNC_CHECK_EN` defined: `frame_sync` is checked in LOCKED as described (realignment + `sync_err`).
- Not defined: `frame_sync` is used only in HUNT. In LOCKED it is ignored, the slot counter free-runs, and `sync_err` is tied to 0.

## Structure
- Package `tdm_pkg`: state encoding (HUNT=0, LOCKED=1), default `N_CH`/`WIDTH`, and slot-width constant `$clog2(N_CH)`. It is shared with the transmit-side mux sequencer.
- One sub-module, `tdm_slot_counter`: a modulo-N_CH counter with `inc` (valid), `load1` (sync realign), and `clr` (reset/HUNT) inputs. The rest is inline.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `din_valid`=1 → all outputs 0, `locked`=0.
- HUNT drop: samples 1,1,0 with no sync, then sync+0,0,1,1 (WIDTH=1) → no pulse for the first three. One `dout_valid` with `dout`=4'b1100 (ch0=0, ch1=0, ch2=1, ch3=1), `locked`=1.
- Streaming: 3 consecutive frames of pattern 0011 (ch0..3 = 1,1,0,0), `din_valid` constant → `dout`=4'b0011, pulses exactly 4 cycles apart.
- Gaps: the same frame with `din_valid` low for 3 cycles between slots 1 and 2 → identical `dout`, pulse after the 4th valid sample only.
- Misalignment (check enabled): sync asserted at `slot`=2 → `sync_err` 1 cycle, no `dout_valid`. The next 3 samples complete the frame, and the new frame lands with sync sample in ch0.
- Reset mid-frame: `rst_n`=0 at `slot`=2 → `dout`=0, state HUNT, and the following non-sync samples are ignored.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: state encoding, default frame geometry and slot width.
// Used by both the receive-side demux and the transmit-side mux sequencer.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_N_CH   = 4;
    localparam int TDM_WIDTH  = 1;
    localparam int TDM_SLOT_W = $clog2(TDM_N_CH);

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter. clr has priority over load1 (realign to slot 1), which has priority over inc.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic          load1,
    output logic [SW-1:0] cnt
);

    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;

    // N_CH is a power of two, so the natural wrap of the SW-bit adder is the modulo.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = SW'(1);
        end else if (inc) begin
            cnt_d = cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/demux_tdm.sv
// TDM receive demultiplexer: aligns on frame_sync, gathers N_CH samples, emits a parallel frame.
// Define DEMUX_TDM_SYNC_CHECK_EN to realign and flag sync_err on frame_sync at a non-zero slot.
module demux_tdm
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int N_CH  = TDM_N_CH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_sync,
    output logic [N_CH*WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic [$clog2(N_CH)-1:0] slot,
    output logic                    locked,
    output logic                    sync_err
);

    localparam int SW = $clog2(N_CH);

    tdm_state_e                       state_q, state_d;
    logic [N_CH-1:0][WIDTH-1:0]       shadow_q, shadow_d;
    logic [N_CH*WIDTH-1:0]            dout_q, dout_d;
    logic                             dout_valid_q, dout_valid_d;
    logic                             sync_err_q, sync_err_d;
    logic [SW-1:0]                    slot_q;

    logic hunt_start;
    logic sync_mis;
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_load1;

    assign hunt_start = (state_q == HUNT) && din_valid && frame_sync;

`ifdef DEMUX_TDM_SYNC_CHECK_EN
    assign sync_mis = (state_q == LOCKED) && din_valid && frame_sync && (slot_q != '0);
`else
    assign sync_mis = 1'b0;
`endif

    assign cnt_clr   = (state_q == HUNT) && !hunt_start;
    assign cnt_load1 = hunt_start || sync_mis;
    assign cnt_inc   = (state_q == LOCKED) && din_valid;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .cnt   (slot_q)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        if (hunt_start) begin
            shadow_d    = '0;
            shadow_d[0] = din;
            state_d     = LOCKED;
        end else if (sync_mis) begin
            // Realign: the partial frame is thrown away and the sync sample restarts slot 0.
            shadow_d    = '0;
            shadow_d[0] = din;
            sync_err_d  = 1'b1;
        end else if ((state_q == LOCKED) && din_valid) begin
            shadow_d[slot_q] = din;
            if (slot_q == SW'(N_CH - 1)) begin
                dout_d       = {din, shadow_q[N_CH-2:0]};
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_demux_tdm.sv
// Directed bench for demux_tdm with WIDTH=1, N_CH=4; expected values are hand-computed.
module tb_demux_tdm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int n_cmp = 0;
    int n_err = 0;

    demux_tdm #(
        .WIDTH (1),
        .N_CH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, then land 1 ns after the following rising edge.
    task automatic step(input logic r, input logic v, input logic s, input logic d);
        @(negedge clk);
        rst_n      = r;
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        din_valid  = 1'b1;
        frame_sync = 1'b0;
        din        = 1'b1;

        // Reset with valid samples present
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("rst_dout",       32'(dout),       32'h0);
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_slot",       32'(slot),       32'h0);
        chk("rst_locked",     32'(locked),     32'h0);
        chk("rst_sync_err",   32'(sync_err),   32'h0);

        // HUNT drops 1,1,0 without sync
        step(1, 1, 0, 1);
        chk("hunt_drop0_slot",   32'(slot),       32'h0);
        chk("hunt_drop0_locked", 32'(locked),     32'h0);
        step(1, 1, 0, 1);
        chk("hunt_drop1_vld",    32'(dout_valid), 32'h0);
        step(1, 1, 0, 0);
        chk("hunt_drop2_vld",    32'(dout_valid), 32'h0);
        chk("hunt_drop2_slot",   32'(slot),       32'h0);

        // Sync + 0,0,1,1 -> dout = 4'b1100
        step(1, 1, 1, 0);
        chk("lock_locked", 32'(locked), 32'h1);
        chk("lock_slot",   32'(slot),   32'h1);
        step(1, 1, 0, 0);
        chk("lock_slot2",  32'(slot),   32'h2);
        step(1, 1, 0, 1);
        chk("lock_slot3",  32'(slot),   32'h3);
        chk("lock_vld3",   32'(dout_valid), 32'h0);
        step(1, 1, 0, 1);
        chk("frame1_vld",  32'(dout_valid), 32'h1);
        chk("frame1_dout", 32'(dout),       32'hC);
        chk("frame1_slot", 32'(slot),       32'h0);
        step(1, 0, 0, 0);
        chk("frame1_pulse_end", 32'(dout_valid), 32'h0);
        chk("frame1_hold",      32'(dout),       32'hC);
        chk("idle_slot",        32'(slot),       32'h0);

        // Three back-to-back frames ch0..3 = 1,1,0,0
        for (int i = 0; i < 12; i++) begin
            step(1, 1, (i % 4) == 0, (i % 4) < 2);
            chk($sformatf("stream_vld_%0d", i), 32'(dout_valid), 32'((i % 4) == 3));
            chk($sformatf("stream_err_%0d", i), 32'(sync_err),   32'h0);
            if ((i % 4) == 3) begin
                chk($sformatf("stream_dout_%0d", i), 32'(dout), 32'h3);
            end
        end

        // Gapped frame: 3 idle cycles between slots 1 and 2
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            chk($sformatf("gap_vld_%0d", i),  32'(dout_valid), 32'h0);
            chk($sformatf("gap_slot_%0d", i), 32'(slot),       32'h2);
        end
        step(1, 1, 0, 0);
        chk("gap_vld_slot2", 32'(dout_valid), 32'h0);
        step(1, 1, 0, 0);
        chk("gap_vld_done",  32'(dout_valid), 32'h1);
        chk("gap_dout",      32'(dout),       32'h3);
        step(1, 0, 0, 0);
        chk("gap_pulse_end", 32'(dout_valid), 32'h0);

        // Sync asserted at slot 2
        step(1, 1, 1, 1);
        step(1, 1, 0, 0);
        chk("mis_pre_slot", 32'(slot), 32'h2);
        step(1, 1, 1, 1);
`ifdef DEMUX_TDM_SYNC_CHECK_EN
        chk("mis_err",      32'(sync_err),   32'h1);
        chk("mis_vld",      32'(dout_valid), 32'h0);
        chk("mis_slot",     32'(slot),       32'h1);
        chk("mis_locked",   32'(locked),     32'h1);
        step(1, 1, 0, 0);
        chk("mis_err_end",  32'(sync_err),   32'h0);
        step(1, 1, 0, 1);
        chk("mis_vld2",     32'(dout_valid), 32'h0);
        step(1, 1, 0, 0);
`else
        chk("mis_err",      32'(sync_err),   32'h0);
        chk("mis_vld",      32'(dout_valid), 32'h0);
        chk("mis_slot",     32'(slot),       32'h3);
        step(1, 1, 0, 0);
`endif
        chk("mis_done_vld",  32'(dout_valid), 32'h1);
        chk("mis_done_dout", 32'(dout),       32'h5);
        chk("mis_done_slot", 32'(slot),       32'h0);

        // Reset mid-frame at slot 2
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        chk("mid_pre_slot", 32'(slot), 32'h2);
        step(0, 1, 0, 1);
        chk("mid_rst_dout",   32'(dout),   32'h0);
        chk("mid_rst_locked", 32'(locked), 32'h0);
        chk("mid_rst_slot",   32'(slot),   32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 1);
            chk($sformatf("mid_hunt_slot_%0d", i),   32'(slot),       32'h0);
            chk($sformatf("mid_hunt_locked_%0d", i), 32'(locked),     32'h0);
            chk($sformatf("mid_hunt_vld_%0d", i),    32'(dout_valid), 32'h0);
        end
        chk("mid_hunt_dout", 32'(dout), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
